// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store port.
// Holds the funct3 codes, FSM state encoding, legal memory strobes and load extension.
// Imported by lsu_align and lsu_mem_port; no ports.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT1 = 2'd1,
    S_BEAT2 = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // The only strobe patterns the data memory accepts.
  localparam logic [3:0] STRB_B0 = 4'b0001;
  localparam logic [3:0] STRB_B1 = 4'b0010;
  localparam logic [3:0] STRB_H0 = 4'b0011;
  localparam logic [3:0] STRB_B2 = 4'b0100;
  localparam logic [3:0] STRB_H1 = 4'b0110;
  localparam logic [3:0] STRB_B3 = 4'b1000;
  localparam logic [3:0] STRB_H2 = 4'b1100;
  localparam logic [3:0] STRB_W  = 4'b1111;

  // Sign/zero extension of right-aligned load data according to funct3.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] raw);
    logic [31:0] res;
    case (f3)
      F3_B:    res = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   res = {24'h0, raw[7:0]};
      F3_H:    res = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   res = {16'h0, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for one memory beat: byte strobes, shifted write data, merged load data.
// Purely combinational, zero latency.
// Ports: off/funct3/split/second describe the access and beat; wdata in; beat1/beat2 read words in.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic        split,
  input  logic        second,
  input  logic [31:0] wdata,
  input  logic [31:0] beat1_dat,
  input  logic [31:0] beat2_dat,
  output logic [3:0]  strb,
  output logic [31:0] wr_din,
  output logic [31:0] ld_data
);

  logic [3:0]  size_mask;
  logic [5:0]  hi_sh;
  logic [31:0] merged;
  logic        is_half;

  always_comb begin
    is_half = (funct3[1:0] == 2'b01);
    case (funct3[1:0])
      2'b01:   size_mask = STRB_H0;
      2'b10:   size_mask = STRB_W;
      default: size_mask = STRB_B0;
    endcase

    // Split accesses only happen for H@3 and W@2: first beat fills the top
    // lanes of the lower word, second beat the bottom lanes of the next word.
    if (!split)       strb = size_mask << off;
    else if (!second) strb = is_half ? STRB_B3 : STRB_H2;
    else              strb = is_half ? STRB_B0 : STRB_H0;

    // Second beat carries the bytes that spilled past lane 3.
    hi_sh  = 6'd32 - {1'b0, off, 3'b000};
    wr_din = second ? (wdata >> hi_sh) : (wdata << {off, 3'b000});

    // For non-split accesses only beat1 lanes reach the low bits.
    merged  = 32'({beat2_dat, beat1_dat} >> {off, 3'b000});
    ld_data = load_extend(funct3, merged);
  end

endmodule

// File: rtl/lsu_mem_port.sv
// MEM-stage load/store initiator: latches one EX request, drives Data_mem beats, returns WB data.
// Ports: req_* handshake from EX, mem_* to the byte-strobed memory, rsp_* one-cycle pulse to WB.
// Latency: 2 cycles to response (3 when split, 1 on error); req_ready high only in IDLE.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter  int Depth = 128,
  parameter  int Width = 32,
  localparam int AW    = $clog2(Depth) + 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [Width-1:0] req_wdata,
  input  logic [4:0]       req_rd,
  output logic             mem_we,
  output logic [3:0]       mem_wr_strb,
  output logic [Width-1:0] mem_wr_din,
  output logic [AW-1:0]    mem_rd_addr,
  output logic [AW-1:0]    mem_wr_addr,
  input  logic [Width-1:0] mem_rd_dout,
  output logic             rsp_valid,
  output logic [Width-1:0] rsp_data,
  output logic [4:0]       rsp_rd,
  output logic             rsp_err
);

  state_e           state_q, state_d;
  logic             we_q, we_d, split_q, split_d;
  logic [2:0]       f3_q, f3_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [Width-1:0] wdata_q, wdata_d, hold_q, hold_d;
  logic [4:0]       rd_q, rd_d, rsp_rd_q, rsp_rd_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [Width-1:0] rsp_data_q, rsp_data_d;

  logic             req_illegal, req_split, req_err;
  logic [1:0]       req_last;
  logic [32:0]      end_addr;
  logic             in_beat;
  logic [AW-1:0]    beat_addr;
  logic [3:0]       al_strb;
  logic [31:0]      al_din, al_ld;

  // Request decode, used only at the accepting edge.
  always_comb begin
    case (req_funct3)
      F3_B, F3_BU: req_last = 2'd0;
      F3_H, F3_HU: req_last = 2'd1;
      default:     req_last = 2'd3;
    endcase
    // Unsigned codes are meaningless for stores.
    req_illegal = !((req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                    (!req_we && ((req_funct3 == F3_BU) || (req_funct3 == F3_HU))));
    end_addr  = {1'b0, req_addr} + {31'd0, req_last};
    req_split = ((req_funct3[1:0] == 2'b01) && (req_addr[1:0] == 2'd3)) ||
                ((req_funct3 == F3_W) && (req_addr[1:0] == 2'd2));
    req_err   = req_illegal || ((req_funct3 == F3_W) && req_addr[0]) ||
                (end_addr >= 33'(4 * Depth)) || (req_addr[31:AW] != '0);
  end

  lsu_align u_align (
    .off       (addr_q[1:0]),
    .funct3    (f3_q),
    .split     (split_q),
    .second    (state_q == S_BEAT2),
    .wdata     (wdata_q),
    .beat1_dat ((state_q == S_BEAT1) ? mem_rd_dout : hold_q),
    .beat2_dat (mem_rd_dout),
    .strb      (al_strb),
    .wr_din    (al_din),
    .ld_data   (al_ld)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    split_d     = split_q;
    hold_d      = hold_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;
    rsp_rd_d    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr[AW-1:0];
          wdata_d = req_wdata;
          rd_d    = req_rd;
          split_d = req_split;
          if (req_err) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rd_d    = req_rd;
          end else begin
            state_d = S_BEAT1;
          end
        end
      end
      S_BEAT1: begin
        if (!we_q) hold_d = mem_rd_dout;
        if (split_q) begin
          state_d = S_BEAT2;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rd_d    = rd_q;
          rsp_data_d  = we_q ? '0 : al_ld;
        end
      end
      S_BEAT2: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_rd_d    = rd_q;
        rsp_data_d  = we_q ? '0 : al_ld;
      end
      S_RESP: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      split_q     <= 1'b0;
      hold_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      split_q     <= split_d;
      hold_q      <= hold_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rd_q    <= rsp_rd_d;
    end
  end

  // Memory side is decoded from registered state only; errored requests
  // never enter a beat state, so they cannot write.
  always_comb begin
    in_beat     = (state_q == S_BEAT1) || (state_q == S_BEAT2);
    beat_addr   = {addr_q[AW-1:2], 2'b00} + ((state_q == S_BEAT2) ? AW'(4) : AW'(0));
    mem_we      = we_q && in_beat;
    mem_wr_strb = mem_we ? al_strb : 4'b0000;
    mem_wr_din  = mem_we ? al_din : '0;
    mem_rd_addr = in_beat ? beat_addr : '0;
    mem_wr_addr = in_beat ? beat_addr : '0;
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_rd    = rsp_rd_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Testbench for lsu_mem_port with a byte-addressed memory model.
// Expected beats/responses are queued at stimulus time and compared against monitored output.
// Timing is checked as cycle offset from the accepting edge.
module tb_lsu_mem_port;
  import lsu_pkg::*;

  typedef struct packed {
    logic [8:0]  addr;
    logic [3:0]  strb;
    logic [31:0] din;
    logic [7:0]  rel;
  } beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [4:0]  rd;
    logic [7:0]  rel;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_we;
  logic [3:0]  mem_wr_strb;
  logic [31:0] mem_wr_din, mem_rd_dout;
  logic [8:0]  mem_rd_addr, mem_wr_addr;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;

  int asserts = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [7:0] mem [0:511];

  beat_t exp_b[$], obs_b[$];
  rsp_t  exp_r[$], obs_r[$];

  lsu_mem_port #(.Depth(128), .Width(32)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_we(mem_we), .mem_wr_strb(mem_wr_strb), .mem_wr_din(mem_wr_din),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_rd_dout(mem_rd_dout),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rd_dout = {mem[mem_rd_addr + 9'd3], mem[mem_rd_addr + 9'd2],
                        mem[mem_rd_addr + 9'd1], mem[mem_rd_addr]};

  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_wr_strb[i]) mem[mem_wr_addr + 9'(i)] <= mem_wr_din[8*i +: 8];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) obs_b.push_back('{mem_wr_addr, mem_wr_strb, mem_wr_din, 8'(cyc - acc_cyc + 1)});
      if (rsp_valid) obs_r.push_back('{rsp_data, rsp_err, rsp_rd, 8'(cyc - acc_cyc + 1)});
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      asserts++;
      fails++;
      $display("FAIL issue_ready_timeout req_ready=%b required 1", req_ready);
    end
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    req_wdata = 32'hFFFF_FFFF;
  endtask

  task automatic settle;
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    asserts++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    asserts++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    asserts++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
    asserts++; if (rsp_data !== 32'h0) begin fails++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
    asserts++; if (rsp_rd !== 5'h0) begin fails++; $display("FAIL reset_rsp_rd got=%h want=0", rsp_rd); end
    asserts++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
    asserts++; if (mem_wr_strb !== 4'h0) begin fails++; $display("FAIL reset_strb got=%b want=0", mem_wr_strb); end
    asserts++; if (mem_wr_din !== 32'h0) begin fails++; $display("FAIL reset_din got=%h want=0", mem_wr_din); end
    asserts++; if ({mem_rd_addr, mem_wr_addr} !== 18'h0) begin fails++; $display("FAIL reset_addr got=%h/%h want=0", mem_rd_addr, mem_wr_addr); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word;
    beat_t eb, ob; rsp_t er, orr;
    exp_b.push_back('{9'h010, 4'b1111, 32'hDEADBEEF, 8'd1});
    exp_r.push_back('{32'h0, 1'b0, 5'd1, 8'd2});
    issue(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 5'd1);
    exp_r.push_back('{32'hDEADBEEF, 1'b0, 5'd2, 8'd2});
    issue(1'b0, F3_W, 32'h10, 32'h0, 5'd2);
    settle();
    asserts++; if (obs_b.size() != exp_b.size()) begin fails++; $display("FAIL word_beat_count got=%0d want=%0d", obs_b.size(), exp_b.size()); end
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      eb = exp_b.pop_front(); ob = obs_b.pop_front(); asserts++;
      if (ob !== eb) begin fails++; $display("FAIL word_beat got a=%h s=%b d=%h c=%0d want a=%h s=%b d=%h c=%0d", ob.addr, ob.strb, ob.din, ob.rel, eb.addr, eb.strb, eb.din, eb.rel); end
    end
    asserts++; if (obs_r.size() != exp_r.size()) begin fails++; $display("FAIL word_rsp_count got=%0d want=%0d", obs_r.size(), exp_r.size()); end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      er = exp_r.pop_front(); orr = obs_r.pop_front(); asserts++;
      if (orr !== er) begin fails++; $display("FAIL word_rsp got d=%h e=%b rd=%0d c=%0d want d=%h e=%b rd=%0d c=%0d", orr.data, orr.err, orr.rd, orr.rel, er.data, er.err, er.rd, er.rel); end
    end
    exp_b.delete(); obs_b.delete(); exp_r.delete(); obs_r.delete();
  endtask

  task automatic test_byte_half;
    beat_t eb, ob; rsp_t er, orr;
    exp_b.push_back('{9'h010, 4'b1000, 32'hA5000000, 8'd1});
    exp_r.push_back('{32'h0, 1'b0, 5'd3, 8'd2});
    issue(1'b1, F3_B, 32'h13, 32'h000000A5, 5'd3);
    exp_r.push_back('{32'hFFFFFFA5, 1'b0, 5'd4, 8'd2});
    issue(1'b0, F3_B, 32'h13, 32'h0, 5'd4);
    exp_r.push_back('{32'h000000A5, 1'b0, 5'd5, 8'd2});
    issue(1'b0, F3_BU, 32'h13, 32'h0, 5'd5);
    exp_b.push_back('{9'h018, 4'b1100, 32'hBEEF0000, 8'd1});
    exp_r.push_back('{32'h0, 1'b0, 5'd6, 8'd2});
    issue(1'b1, F3_H, 32'h1A, 32'h0000BEEF, 5'd6);
    exp_r.push_back('{32'hFFFFBEEF, 1'b0, 5'd7, 8'd2});
    issue(1'b0, F3_H, 32'h1A, 32'h0, 5'd7);
    exp_r.push_back('{32'h0000BEEF, 1'b0, 5'd8, 8'd2});
    issue(1'b0, F3_HU, 32'h1A, 32'h0, 5'd8);
    settle();
    asserts++; if (obs_b.size() != exp_b.size()) begin fails++; $display("FAIL byte_beat_count got=%0d want=%0d", obs_b.size(), exp_b.size()); end
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      eb = exp_b.pop_front(); ob = obs_b.pop_front(); asserts++;
      if (ob !== eb) begin fails++; $display("FAIL byte_beat got a=%h s=%b d=%h c=%0d want a=%h s=%b d=%h c=%0d", ob.addr, ob.strb, ob.din, ob.rel, eb.addr, eb.strb, eb.din, eb.rel); end
    end
    asserts++; if (obs_r.size() != exp_r.size()) begin fails++; $display("FAIL byte_rsp_count got=%0d want=%0d", obs_r.size(), exp_r.size()); end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      er = exp_r.pop_front(); orr = obs_r.pop_front(); asserts++;
      if (orr !== er) begin fails++; $display("FAIL byte_rsp got d=%h e=%b rd=%0d c=%0d want d=%h e=%b rd=%0d c=%0d", orr.data, orr.err, orr.rd, orr.rel, er.data, er.err, er.rd, er.rel); end
    end
    exp_b.delete(); obs_b.delete(); exp_r.delete(); obs_r.delete();
  endtask

  task automatic test_split;
    beat_t eb, ob; rsp_t er, orr;
    exp_b.push_back('{9'h014, 4'b1000, 32'h34000000, 8'd1});
    exp_b.push_back('{9'h018, 4'b0001, 32'h00000012, 8'd2});
    exp_r.push_back('{32'h0, 1'b0, 5'd9, 8'd3});
    issue(1'b1, F3_H, 32'h17, 32'h00001234, 5'd9);
    exp_r.push_back('{32'h00001234, 1'b0, 5'd10, 8'd3});
    issue(1'b0, F3_H, 32'h17, 32'h0, 5'd10);
    exp_b.push_back('{9'h020, 4'b1100, 32'hF00D0000, 8'd1});
    exp_b.push_back('{9'h024, 4'b0011, 32'h0000CAFE, 8'd2});
    exp_r.push_back('{32'h0, 1'b0, 5'd11, 8'd3});
    issue(1'b1, F3_W, 32'h22, 32'hCAFEF00D, 5'd11);
    exp_r.push_back('{32'hCAFEF00D, 1'b0, 5'd12, 8'd3});
    issue(1'b0, F3_W, 32'h22, 32'h0, 5'd12);
    settle();
    asserts++; if (obs_b.size() != exp_b.size()) begin fails++; $display("FAIL split_beat_count got=%0d want=%0d", obs_b.size(), exp_b.size()); end
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      eb = exp_b.pop_front(); ob = obs_b.pop_front(); asserts++;
      if (ob !== eb) begin fails++; $display("FAIL split_beat got a=%h s=%b d=%h c=%0d want a=%h s=%b d=%h c=%0d", ob.addr, ob.strb, ob.din, ob.rel, eb.addr, eb.strb, eb.din, eb.rel); end
    end
    asserts++; if (obs_r.size() != exp_r.size()) begin fails++; $display("FAIL split_rsp_count got=%0d want=%0d", obs_r.size(), exp_r.size()); end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      er = exp_r.pop_front(); orr = obs_r.pop_front(); asserts++;
      if (orr !== er) begin fails++; $display("FAIL split_rsp got d=%h e=%b rd=%0d c=%0d want d=%h e=%b rd=%0d c=%0d", orr.data, orr.err, orr.rd, orr.rel, er.data, er.err, er.rd, er.rel); end
    end
    exp_b.delete(); obs_b.delete(); exp_r.delete(); obs_r.delete();
  endtask

  task automatic test_errors;
    rsp_t er, orr;
    exp_r.push_back('{32'h0, 1'b1, 5'd13, 8'd1});
    issue(1'b0, F3_W, 32'h21, 32'h0, 5'd13);
    exp_r.push_back('{32'h0, 1'b1, 5'd14, 8'd1});
    issue(1'b1, 3'b011, 32'h30, 32'h11111111, 5'd14);
    exp_r.push_back('{32'h0, 1'b1, 5'd15, 8'd1});
    issue(1'b1, F3_W, 32'd512, 32'h22222222, 5'd15);
    exp_r.push_back('{32'h0, 1'b1, 5'd16, 8'd1});
    issue(1'b1, F3_W, 32'd510, 32'h33333333, 5'd16);
    exp_r.push_back('{32'h0, 1'b1, 5'd17, 8'd1});
    issue(1'b1, F3_BU, 32'h40, 32'h44444444, 5'd17);
    settle();
    asserts++; if (obs_b.size() != 0) begin fails++; $display("FAIL err_mem_we_beats got=%0d want=0", obs_b.size()); end
    asserts++; if (obs_r.size() != exp_r.size()) begin fails++; $display("FAIL err_rsp_count got=%0d want=%0d", obs_r.size(), exp_r.size()); end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      er = exp_r.pop_front(); orr = obs_r.pop_front(); asserts++;
      if (orr !== er) begin fails++; $display("FAIL err_rsp got d=%h e=%b rd=%0d c=%0d want d=%h e=%b rd=%0d c=%0d", orr.data, orr.err, orr.rd, orr.rel, er.data, er.err, er.rd, er.rel); end
    end
    exp_b.delete(); obs_b.delete(); exp_r.delete(); obs_r.delete();
  endtask

  task automatic test_reset_mid;
    beat_t eb, ob; rsp_t er, orr;
    exp_b.push_back('{9'h014, 4'b1000, 32'h78000000, 8'd1});
    issue(1'b1, F3_H, 32'h17, 32'h00005678, 5'd20);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    asserts++; if (req_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready got=%b want=1", req_ready); end
    asserts++; if (mem_we !== 1'b0) begin fails++; $display("FAIL midreset_mem_we got=%b want=0", mem_we); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    asserts++; if (obs_r.size() != 0) begin fails++; $display("FAIL midreset_no_rsp got=%0d want=0", obs_r.size()); end
    obs_r.delete();
    exp_r.push_back('{32'h78000000, 1'b0, 5'd21, 8'd2});
    issue(1'b0, F3_W, 32'h14, 32'h0, 5'd21);
    settle();
    asserts++; if (obs_b.size() != exp_b.size()) begin fails++; $display("FAIL midreset_beat_count got=%0d want=%0d", obs_b.size(), exp_b.size()); end
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      eb = exp_b.pop_front(); ob = obs_b.pop_front(); asserts++;
      if (ob !== eb) begin fails++; $display("FAIL midreset_beat got a=%h s=%b d=%h c=%0d want a=%h s=%b d=%h c=%0d", ob.addr, ob.strb, ob.din, ob.rel, eb.addr, eb.strb, eb.din, eb.rel); end
    end
    asserts++; if (obs_r.size() != exp_r.size()) begin fails++; $display("FAIL midreset_rsp_count got=%0d want=%0d", obs_r.size(), exp_r.size()); end
    while (exp_r.size() > 0 && obs_r.size() > 0) begin
      er = exp_r.pop_front(); orr = obs_r.pop_front(); asserts++;
      if (orr !== er) begin fails++; $display("FAIL midreset_rsp got d=%h e=%b rd=%0d c=%0d want d=%h e=%b rd=%0d c=%0d", orr.data, orr.err, orr.rd, orr.rel, er.data, er.err, er.rd, er.rel); end
    end
    exp_b.delete(); obs_b.delete(); exp_r.delete(); obs_r.delete();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    test_reset();
    test_word();
    test_byte_half();
    test_split();
    test_errors();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
